// File: rtl/hostctrl_pkg.sv
// Shared types and constants for the host-controller Wishbone loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hostctrl_pkg;

    typedef enum logic [2:0] {
        ST_RX       = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WB       = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_FINISHED = 3'd4
    } state_t;

    // A record is 4 address bytes followed by 4 data bytes, LSB first.
    localparam int         BYTES_PER_REC = 8;
    localparam logic [2:0] LAST_IDX      = 3'(BYTES_PER_REC - 1);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [3:0] SEL_WORD    = 4'hF;

endpackage

// File: rtl/hostctrl_byte_asm.sv
// Assembles host bytes into a 32-bit address word and a 32-bit data word.
// Latency: a written byte is visible on the outputs one edge after i_wr.
// Backpressure: none; the caller strobes i_wr once per accepted byte.
module hostctrl_byte_asm (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_wr,
    input  logic [2:0]  i_idx,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_addr,
    output logic [31:0] o_data
);

    logic [31:0] r_addr;
    logic [31:0] r_data;

    // Index bit 2 selects address (0..3) or data (4..7); low bits pick the byte lane.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (i_wr) begin
            if (!i_idx[2]) begin
                r_addr[{i_idx[1:0], 3'b000} +: 8] <= i_byte;
            end else begin
                r_data[{i_idx[1:0], 3'b000} +: 8] <= i_byte;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/hostctrl_wb_loader.sv
// Loads host byte records into memory as classic Wishbone single writes; holds CPU in reset until done.
// Latency: ack_data one edge after valid sampled; cyc one edge after 8th valid falls; ack two edges after wb_ack.
// Backpressure: four-phase per byte (ack_data held until valid drops); no new byte accepted until record commits.
module hostctrl_wb_loader
    import hostctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [7:0]       hostctrl_data_i,
    input  logic             hostctrl_valid_i,
    input  logic             hostctrl_done_i,
    output logic             hostctrl_ack_data_o,
    output logic             hostctrl_ack_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic             loading_o,
    output logic             err_o,
    output logic [CNT_W-1:0] words_o
);

    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic             r_ack_data, w_ack_data_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_cyc, w_cyc_nxt;
    logic [31:0]      r_adr, w_adr_nxt;
    logic [31:0]      r_dat, w_dat_nxt;
    logic [3:0]       r_sel, w_sel_nxt;
    logic             r_loading, w_loading_nxt;
    logic             r_err, w_err_nxt;
    logic [CNT_W-1:0] r_words, w_words_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;

    logic             w_asm_wr;
    logic             w_asm_clr;
    logic [31:0]      w_addr;
    logic [31:0]      w_data;
    logic             w_unused;

    // Read data is never consumed by a write-only master.
    assign w_unused = ^wb_dat_i;

    hostctrl_byte_asm u_byte_asm (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_clr  (w_asm_clr),
        .i_wr   (w_asm_wr),
        .i_idx  (r_idx),
        .i_byte (hostctrl_data_i),
        .o_addr (w_addr),
        .o_data (w_data)
    );

    // State and all registered outputs; reset aborts any bus cycle in flight.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_RX;
            r_idx      <= '0;
            r_ack_data <= 1'b0;
            r_ack      <= 1'b0;
            r_cyc      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_loading  <= 1'b1;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_ack_data <= w_ack_data_nxt;
            r_ack      <= w_ack_nxt;
            r_cyc      <= w_cyc_nxt;
            r_adr      <= w_adr_nxt;
            r_dat      <= w_dat_nxt;
            r_sel      <= w_sel_nxt;
            r_loading  <= w_loading_nxt;
            r_err      <= w_err_nxt;
            r_words    <= w_words_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state says otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_ack_data_nxt = r_ack_data;
        w_ack_nxt      = r_ack;
        w_cyc_nxt      = r_cyc;
        w_adr_nxt      = r_adr;
        w_dat_nxt      = r_dat;
        w_sel_nxt      = r_sel;
        w_loading_nxt  = r_loading;
        w_err_nxt      = r_err;
        w_words_nxt    = r_words;
        w_to_cnt_nxt   = r_to_cnt;
        w_asm_wr       = 1'b0;
        w_asm_clr      = 1'b0;

        case (r_state)
            ST_RX: begin
                // Done beats valid; a partial record is simply thrown away.
                if (hostctrl_done_i) begin
                    w_state_nxt    = ST_FINISHED;
                    w_asm_clr      = 1'b1;
                    w_idx_nxt      = '0;
                    w_ack_nxt      = 1'b0;
                    w_ack_data_nxt = 1'b0;
                    w_loading_nxt  = 1'b0;
                end else if (hostctrl_valid_i) begin
                    w_asm_wr       = 1'b1;
                    w_ack_data_nxt = 1'b1;
                    w_ack_nxt      = 1'b0;
                    w_state_nxt    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the host to drop valid so a long valid is one byte.
                if (!hostctrl_valid_i) begin
                    w_ack_data_nxt = 1'b0;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt    = '0;
                        w_state_nxt  = ST_WB;
                        w_cyc_nxt    = 1'b1;
                        w_adr_nxt    = {w_addr[31:2], 2'b00};
                        w_dat_nxt    = w_data;
                        w_sel_nxt    = SEL_WORD;
                        w_to_cnt_nxt = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = ST_RX;
                    end
                end
            end
            ST_WB: begin
                if (wb_err_i || wb_ack_i || (r_to_cnt == TO_LAST)) begin
                    w_cyc_nxt   = 1'b0;
                    w_sel_nxt   = '0;
                    w_state_nxt = ST_COMMIT;
                    // Error if the slave flagged one, or if we left without an ack.
                    if (wb_err_i || !wb_ack_i) begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            ST_COMMIT: begin
                // Acknowledge even after an error so the host can always proceed.
                w_ack_nxt   = 1'b1;
                w_words_nxt = r_words + CNT_W'(1);
                w_state_nxt = ST_RX;
            end
            ST_FINISHED: begin
                w_loading_nxt  = 1'b0;
                w_ack_nxt      = 1'b0;
                w_ack_data_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RX;
            end
        endcase
    end

    assign hostctrl_ack_data_o = r_ack_data;
    assign hostctrl_ack_o      = r_ack;
    assign wb_adr_o            = r_adr;
    assign wb_dat_o            = r_dat;
    assign wb_sel_o            = r_sel;
    assign wb_cyc_o            = r_cyc;
    assign wb_stb_o            = r_cyc;
    assign wb_we_o             = r_cyc;
    assign wb_cti_o            = CTI_CLASSIC;
    assign wb_bte_o            = BTE_LINEAR;
    assign loading_o           = r_loading;
    assign err_o               = r_err;
    assign words_o             = r_words;

endmodule
